// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters:
//   port 0 = execute stage, port 1 = branch/address unit.
// A round-robin arbiter accepts one request at a time using a valid/ready
// handshake. It registers the winner's operands and control into the ALU
// input registers, captures the ALU outputs one cycle later, and presents
// them to the winner with a valid/ready response handshake.
// Each operation passes through IDLE -> ISSUE -> RESP, so one operation
// takes at least three cycles.
//
// Ports (requester i occupies slice [i*N +: N] of each packed request bus)
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush_i               synchronous abort of any in-flight operation
//   req_valid_i[1:0]      request valid per requester
//   req_ready_o[1:0]      request accepted this cycle (IDLE only)
//   req_opd_i             {opd4,opd3,opd2,opd1} per requester
//   req_pc_i              pc per requester
//   req_ctrl_i            {pc_sel, op_sel[2:0], mux2_sel[1:0], mux1_sel} per requester
//   rsp_valid_o[1:0]      one-hot response valid toward the owner
//   rsp_ready_i[1:0]      response consumed (only the owner's bit matters)
//   rsp_result_o          captured alu_result
//   rsp_comp_o            captured comp_result
//   busy_o                an operation is in flight
//   alu_*_o               registered operands/control toward the ALU
//   alu_result_i          combinational result from the ALU
//   comp_result_i         combinational compare result from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int OPERAND_LENGTH = 32,
    parameter int PC_LENGTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [1:0]                    req_valid_i,
    output logic [1:0]                    req_ready_o,
    input  logic [2*4*OPERAND_LENGTH-1:0] req_opd_i,
    input  logic [2*PC_LENGTH-1:0]        req_pc_i,
    input  logic [13:0]                   req_ctrl_i,
    output logic [1:0]                    rsp_valid_o,
    input  logic [1:0]                    rsp_ready_i,
    output logic [OPERAND_LENGTH-1:0]     rsp_result_o,
    output logic [OPERAND_LENGTH-1:0]     rsp_comp_o,
    output logic                          busy_o,
    output logic [OPERAND_LENGTH-1:0]     alu_opd1_o,
    output logic [OPERAND_LENGTH-1:0]     alu_opd2_o,
    output logic [OPERAND_LENGTH-1:0]     alu_opd3_o,
    output logic [OPERAND_LENGTH-1:0]     alu_opd4_o,
    output logic [PC_LENGTH-1:0]          alu_pc_o,
    output logic                          alu_mux1_select_o,
    output logic [1:0]                    alu_mux2_select_o,
    output logic [2:0]                    alu_op_select_o,
    output logic                          alu_pc_select_o,
    input  logic [OPERAND_LENGTH-1:0]     alu_result_i,
    input  logic [OPERAND_LENGTH-1:0]     comp_result_i
);

    localparam int OL     = OPERAND_LENGTH;
    localparam int PL     = PC_LENGTH;
    localparam int OPD_W  = 4 * OL;
    localparam int CTRL_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    state_e              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic [1:0]          rsp_valid_q,  rsp_valid_d;
    logic                busy_q,       busy_d;
    logic [OPD_W-1:0]    alu_opd_q,    alu_opd_d;
    logic [PL-1:0]       alu_pc_q,     alu_pc_d;
    logic [CTRL_W-1:0]   alu_ctrl_q,   alu_ctrl_d;
    logic [OL-1:0]       rsp_result_q, rsp_result_d;
    logic [OL-1:0]       rsp_comp_q,   rsp_comp_d;

    logic                grant_s;
    logic                any_valid_s;
    logic                accept_s;
    logic                capture_s;
    logic [1:0]          req_ready_s;
    logic [OPD_W-1:0]    win_opd_s;
    logic [PL-1:0]       win_pc_s;
    logic [CTRL_W-1:0]   win_ctrl_s;

    // Round-robin pick: a lone requester wins, and a tie goes to the port that did not win last.
    always_comb begin
        grant_s     = 1'b0;
        any_valid_s = |req_valid_i;
        if (req_valid_i == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (req_valid_i[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Acceptance happens only in IDLE, and a flush blocks it in the same cycle.
    always_comb begin
        accept_s    = 1'b0;
        req_ready_s = 2'b00;
        if ((state_q == ST_IDLE) && any_valid_s && !flush_i) begin
            accept_s = 1'b1;
            if (grant_s) begin
                req_ready_s = 2'b10;
            end else begin
                req_ready_s = 2'b01;
            end
        end else begin
            accept_s    = 1'b0;
            req_ready_s = 2'b00;
        end
    end

    // The ready path is combinational, so it is masked by reset to keep every output low during reset.
    assign req_ready_o = req_ready_s & {2{rst_n}};

    // Select the winner's request fields for loading into the ALU input registers.
    always_comb begin
        win_opd_s  = '0;
        win_pc_s   = '0;
        win_ctrl_s = '0;
        if (grant_s) begin
            win_opd_s  = req_opd_i[OPD_W +: OPD_W];
            win_pc_s   = req_pc_i[PL +: PL];
            win_ctrl_s = req_ctrl_i[CTRL_W +: CTRL_W];
        end else begin
            win_opd_s  = req_opd_i[0 +: OPD_W];
            win_pc_s   = req_pc_i[0 +: PL];
            win_ctrl_s = req_ctrl_i[0 +: CTRL_W];
        end
    end

    // Next-state logic for the operation sequencer. last_grant also serves as the owner of the in-flight operation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_ISSUE;
                    last_grant_d = grant_s;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (rsp_ready_i[last_grant_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response valid and busy are registered, derived from the state being entered.
    always_comb begin
        rsp_valid_d = 2'b00;
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_RESP) begin
            if (last_grant_q) begin
                rsp_valid_d = 2'b10;
            end else begin
                rsp_valid_d = 2'b01;
            end
        end else begin
            rsp_valid_d = 2'b00;
        end
    end

    // ALU input registers load only on acceptance and otherwise keep their last value.
    always_comb begin
        alu_opd_d  = alu_opd_q;
        alu_pc_d   = alu_pc_q;
        alu_ctrl_d = alu_ctrl_q;
        if (accept_s) begin
            alu_opd_d  = win_opd_s;
            alu_pc_d   = win_pc_s;
            alu_ctrl_d = win_ctrl_s;
        end else begin
            alu_opd_d  = alu_opd_q;
            alu_pc_d   = alu_pc_q;
            alu_ctrl_d = alu_ctrl_q;
        end
    end

    // Capture ALU outputs at the end of ISSUE. A flushed operation is not captured.
    always_comb begin
        capture_s    = (state_q == ST_ISSUE) && !flush_i;
        rsp_result_d = rsp_result_q;
        rsp_comp_d   = rsp_comp_q;
        if (capture_s) begin
            rsp_result_d = alu_result_i;
            rsp_comp_d   = comp_result_i;
        end else begin
            rsp_result_d = rsp_result_q;
            rsp_comp_d   = rsp_comp_q;
        end
    end

    // Sequencer state and round-robin history. Reset favours port 0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Registers driving the ALU inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opd_q  <= '0;
            alu_pc_q   <= '0;
            alu_ctrl_q <= '0;
        end else begin
            alu_opd_q  <= alu_opd_d;
            alu_pc_q   <= alu_pc_d;
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    // Captured response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            rsp_comp_q   <= '0;
        end else begin
            rsp_result_q <= rsp_result_d;
            rsp_comp_q   <= rsp_comp_d;
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign busy_o            = busy_q;
    assign rsp_result_o      = rsp_result_q;
    assign rsp_comp_o        = rsp_comp_q;
    assign alu_opd1_o        = alu_opd_q[0*OL +: OL];
    assign alu_opd2_o        = alu_opd_q[1*OL +: OL];
    assign alu_opd3_o        = alu_opd_q[2*OL +: OL];
    assign alu_opd4_o        = alu_opd_q[3*OL +: OL];
    assign alu_pc_o          = alu_pc_q;
    assign alu_mux1_select_o = alu_ctrl_q[0];
    assign alu_mux2_select_o = alu_ctrl_q[2:1];
    assign alu_op_select_o   = alu_ctrl_q[5:3];
    assign alu_pc_select_o   = alu_ctrl_q[6];

endmodule
